// File: rtl/seq_alu_md.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide with a start/busy/done handshake.
module seq_alu_md #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_MD = 1,
  parameter int SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_SHR = 5'd4;
  localparam logic [4:0] OP_SHL = 5'd5;
  localparam logic [4:0] OP_ROR = 5'd6;
  localparam logic [4:0] OP_ROL = 5'd7;
  localparam logic [4:0] OP_AND = 5'd8;
  localparam logic [4:0] OP_OR  = 5'd9;
  localparam logic [4:0] OP_NEG = 5'd10;
  localparam logic [4:0] OP_NOT = 5'd11;
  localparam logic [4:0] OP_SRA = 5'd12;

  localparam logic [SHW:0] WBITS = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state, state_nx;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div, neg_q, neg_r;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_legal, is_md;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic             accept, load_md, sc_write, dz_write, ill_write, fix_write, iter_step;

  logic [WIDTH:0]   sum, sh;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign amt   = b[SHW-1:0];
  assign is_md = (op == OP_MUL) || (op == OP_DIV);
  assign a_neg = (SIGNED_MD != 0) && a[WIDTH-1];
  assign b_neg = (SIGNED_MD != 0) && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  always_comb begin
    sc_res   = '0;
    sc_legal = 1'b1;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_SHR:  sc_res = a >> amt;
      OP_SHL:  sc_res = a << amt;
      OP_ROR:  sc_res = (a >> amt) | (a << (WBITS - {1'b0, amt}));
      OP_ROL:  sc_res = (a << amt) | (a >> (WBITS - {1'b0, amt}));
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NEG:  sc_res = -a;
      OP_NOT:  sc_res = ~a;
      OP_SRA:  sc_res = $signed(a) >>> amt;
      default: sc_legal = 1'b0;
    endcase
  end

  // One iteration step: multiply adds the multiplicand and shifts {hi,lo} right;
  // divide shifts the dividend into the remainder and subtracts when it fits.
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    sh  = {acc_hi, acc_lo[WIDTH-1]};
    ge  = sh >= {1'b0, opnd};
    if (is_div) begin
      step_hi = ge ? (sh[WIDTH-1:0] - opnd) : sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    q_fix    = neg_q ? -step_lo : step_lo;
    r_fix    = neg_r ? -step_hi : step_hi;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  // The final step is folded into FIX so the result lands WIDTH edges after sampling.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    accept    = 1'b0;
    load_md   = 1'b0;
    sc_write  = 1'b0;
    dz_write  = 1'b0;
    ill_write = 1'b0;
    fix_write = 1'b0;
    iter_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op == OP_DIV && b == '0) begin
            dz_write = 1'b1;
          end else if (is_md) begin
            load_md  = 1'b1;
            state_nx = ITER;
          end else if (sc_legal) begin
            sc_write = 1'b1;
          end else begin
            ill_write = 1'b1;
          end
        end
      end
      ITER: begin
        busy      = 1'b1;
        iter_step = 1'b1;
        if (cnt == SHW'(1)) state_nx = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        fix_write = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      z_hi     <= '0;
      z_lo     <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= sc_write | dz_write | ill_write | fix_write;
      if (accept) begin
        div_zero <= dz_write;
        illegal  <= ill_write;
      end
      if (sc_write) begin
        z_lo <= sc_res;
        z_hi <= '0;
      end
      if (dz_write) begin
        z_lo <= '1;
        z_hi <= a;
      end
      if (load_md) begin
        is_div <= (op == OP_DIV);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        acc_hi <= '0;
        acc_lo <= (op == OP_DIV) ? mag_a : mag_b;
        opnd   <= (op == OP_DIV) ? mag_b : mag_a;
        cnt    <= SHW'(WIDTH-1);
      end
      if (iter_step) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - 1'b1;
      end
      if (fix_write) begin
        if (is_div) begin
          z_hi <= r_fix;
          z_lo <= q_fix;
        end else begin
          z_hi <= prod_fix[2*WIDTH-1:WIDTH];
          z_lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_md.sv
// Self-checking bench for seq_alu_md: a signed and an unsigned instance share
// stimulus and are compared every cycle against a cycle-level behavioural model.
module tb_seq_alu_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;

  logic [W-1:0] s_hi, s_lo, u_hi, u_lo;
  logic         s_busy, s_done, s_dz, s_ill;
  logic         u_busy, u_done, u_dz, u_ill;

  int total = 0;
  int bad   = 0;
  int lat, busyc, nd, dc;

  always #5 clk = ~clk;

  seq_alu_md #(.WIDTH(W), .SIGNED_MD(1)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .z_hi(s_hi), .z_lo(s_lo), .busy(s_busy), .done(s_done),
    .div_zero(s_dz), .illegal(s_ill)
  );

  seq_alu_md #(.WIDTH(W), .SIGNED_MD(0)) dut_u (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .z_hi(u_hi), .z_lo(u_lo), .busy(u_busy), .done(u_done),
    .div_zero(u_dz), .illegal(u_ill)
  );

  // Reference arithmetic for mul/div, returned as {hi, lo}
  function automatic logic [63:0] ref_md(input logic [4:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input bit sgn);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    res = '0;
    if (o == 5'd2) begin
      res = sgn ? 64'(sx * sy) : 64'(ux * uy);
    end else if (y != 0) begin
      if (sgn) res = {32'(sx % sy), 32'(sx / sy)};
      else     res = {32'(ux % uy), 32'(ux / uy)};
    end
    return res;
  endfunction

  function automatic logic [31:0] ref_single(input logic [4:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    int n;
    logic [31:0] r;
    n = int'(y[4:0]);
    r = x;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd4:  r = x >> n;
      5'd5:  r = x << n;
      5'd6:  for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      5'd7:  for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
      5'd8:  r = x & y;
      5'd9:  r = x | y;
      5'd10: r = 32'd0 - x;
      5'd11: r = ~x;
      5'd12: for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycle-level model: a countdown stands in for the iteration, results are plain arithmetic
  int           m_cnt;
  logic         m_done, m_dz, m_ill;
  logic [W-1:0] m_hi [2];
  logic [W-1:0] m_lo [2];
  logic [63:0]  p_res [2];
  logic [63:0]  r_md [2];
  logic [W-1:0] r_sc;

  always_comb begin
    r_md[0] = ref_md(op, a, b, 1'b0);
    r_md[1] = ref_md(op, a, b, 1'b1);
    r_sc    = ref_single(op, a, b);
  end

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_ill  <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_hi[s]  <= '0;
        m_lo[s]  <= '0;
        p_res[s] <= '0;
      end
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          for (int s = 0; s < 2; s++) begin
            m_hi[s] <= p_res[s][63:32];
            m_lo[s] <= p_res[s][31:0];
          end
        end
      end else if (start) begin
        m_dz  <= 1'b0;
        m_ill <= 1'b0;
        if (op > 5'd12) begin
          m_done <= 1'b1;
          m_ill  <= 1'b1;
        end else if (op == 5'd3 && b == '0) begin
          m_done <= 1'b1;
          m_dz   <= 1'b1;
          for (int s = 0; s < 2; s++) begin
            m_hi[s] <= a;
            m_lo[s] <= '1;
          end
        end else if (op == 5'd2 || op == 5'd3) begin
          m_cnt <= W;
          for (int s = 0; s < 2; s++) p_res[s] <= r_md[s];
        end else begin
          m_done <= 1'b1;
          for (int s = 0; s < 2; s++) begin
            m_hi[s] <= '0;
            m_lo[s] <= r_sc;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("signed_z", {s_hi, s_lo}, {m_hi[1], m_lo[1]});
    checkOutput("unsigned_z", {u_hi, u_lo}, {m_hi[0], m_lo[0]});
    checkOutput("signed_ctl", {60'b0, s_busy, s_done, s_dz, s_ill},
                {60'b0, (m_cnt != 0), m_done, m_dz, m_ill});
    checkOutput("unsigned_ctl", {60'b0, u_busy, u_done, u_dz, u_ill},
                {60'b0, (m_cnt != 0), m_done, m_dz, m_ill});
  end

  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit now);
    if (!now) @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 5'($urandom);
  endtask

  task automatic waitDone(input int budget, output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (s_done) begin
        l = i;
        break;
      end
      if (s_busy) bc++;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pickOp();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3)       return 5'(2 + $urandom_range(0, 1));
    else if (r == 3) return 5'($urandom_range(13, 31));
    else             return 5'($urandom_range(0, 12));
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] seq_alu_md bench starting");
    checkOutput("model_mul", ref_md(5'd2, -32'sd3, 32'd7, 1'b1), 64'hFFFFFFFF_FFFFFFEB);
    checkOutput("model_mul_u", ref_md(5'd2, -32'sd3, 32'd7, 1'b0), 64'h00000006_FFFFFFEB);
    checkOutput("model_div", ref_md(5'd3, -32'sd7, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("model_rol", {32'b0, ref_single(5'd7, 32'h80000001, 32'd4)}, 64'h18);
    checkOutput("model_sra", {32'b0, ref_single(5'd12, 32'h80000000, 32'd4)}, 64'hF8000000);

    #3 clr = 1'b0;
    @(negedge clk);
    checkOutput("reset_s", {s_hi, s_lo, 28'b0, s_busy, s_done, s_dz, s_ill}, '0);
    checkOutput("reset_u", {u_hi, u_lo, 28'b0, u_busy, u_done, u_dz, u_ill}, '0);
    @(negedge clk);
    clr = 1'b1;

    applyStimulus(5'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("add_latency", lat, 1);
    checkOutput("add_wrap", {s_hi, s_lo}, 64'h0);
    @(negedge clk);
    checkOutput("done_single_pulse", {63'b0, s_done}, 64'h0);

    applyStimulus(5'd7, 32'h80000001, 32'd4, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("rol", {s_hi, s_lo}, 64'h00000000_00000018);

    applyStimulus(5'd12, 32'h80000000, 32'd4, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("sra", {s_hi, s_lo}, 64'h00000000_F8000000);

    applyStimulus(5'd6, 32'h12345678, 32'h25, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("ror_amt5", {s_hi, s_lo}, 64'h00000000_C091A2B3);

    applyStimulus(5'd2, -32'sd3, 32'd7, 1'b0);
    waitDone(40, lat, busyc);
    checkOutput("mul_latency", lat, 33);
    checkOutput("mul_busy_cycles", busyc, 32);
    checkOutput("mul_busy_low_at_done", {63'b0, s_busy}, 64'h0);
    checkOutput("mul_signed", {s_hi, s_lo}, 64'hFFFFFFFF_FFFFFFEB);
    checkOutput("mul_unsigned", {u_hi, u_lo}, 64'h00000006_FFFFFFEB);
    // back-to-back: start again in the done cycle
    applyStimulus(5'd2, 32'd100, -32'sd2, 1'b1);
    waitDone(40, lat, busyc);
    checkOutput("b2b_latency", lat, 33);
    checkOutput("b2b_signed", {s_hi, s_lo}, 64'hFFFFFFFF_FFFFFF38);
    checkOutput("b2b_unsigned", {u_hi, u_lo}, 64'h00000063_FFFFFF38);

    applyStimulus(5'd3, -32'sd7, 32'd2, 1'b0);
    waitDone(40, lat, busyc);
    checkOutput("div_signed", {s_hi, s_lo}, 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("div_unsigned", {u_hi, u_lo}, 64'h00000001_7FFFFFFC);

    applyStimulus(5'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    waitDone(40, lat, busyc);
    checkOutput("div_minneg", {s_hi, s_lo, 31'b0, s_dz}, {64'h00000000_80000000, 32'b0});
    checkOutput("div_minneg_u", {u_hi, u_lo}, 64'h80000000_00000000);

    applyStimulus(5'd3, 32'd5, 32'd0, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("divzero_latency", lat, 1);
    checkOutput("divzero_result", {s_hi, s_lo, 31'b0, s_dz}, {64'h00000005_FFFFFFFF, 32'd1});
    applyStimulus(5'd0, 32'd1, 32'd2, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("divzero_cleared", {s_hi, s_lo, 31'b0, s_dz}, {64'h00000000_00000003, 32'd0});

    applyStimulus(5'd20, 32'hDEADBEEF, 32'h1234, 1'b0);
    waitDone(5, lat, busyc);
    checkOutput("illegal_latency", lat, 1);
    checkOutput("illegal_hold", {s_hi, s_lo, 31'b0, s_ill}, {64'h00000000_00000003, 32'd1});

    // start pulsed while a multiply is iterating must be ignored
    applyStimulus(5'd2, 32'd1234, 32'd5678, 1'b0);
    nd = 0;
    dc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (s_done) begin
        nd++;
        dc = c;
      end
      if (c == 10) begin
        start = 1'b1;
        op    = 5'd0;
        a     = 32'd9;
        b     = 32'd9;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("ignored_start_dones", nd, 1);
    checkOutput("ignored_start_cycle", dc, 33);
    checkOutput("ignored_start_prod", {s_hi, s_lo}, 64'd7006652);

    // asynchronous abort mid-iteration
    applyStimulus(5'd2, 32'h12345, 32'h777, 1'b0);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    checkOutput("abort_s", {s_hi, s_lo, 28'b0, s_busy, s_done, s_dz, s_ill}, '0);
    checkOutput("abort_u", {u_hi, u_lo, 28'b0, u_busy, u_done, u_dz, u_ill}, '0);
    @(negedge clk);
    clr = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_done || u_done) nd++;
    end
    checkOutput("abort_no_done", nd, 0);
    applyStimulus(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitDone(40, lat, busyc);
    checkOutput("post_abort_latency", lat, 33);
    checkOutput("post_abort_signed", {s_hi, s_lo}, 64'h00000000_00000001);
    checkOutput("post_abort_unsigned", {u_hi, u_lo}, 64'hFFFFFFFE_00000001);

    // randomized traffic, including starts while busy and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      clr   = 1'b1;
      start = ($urandom_range(0, 2) == 0);
      op    = pickOp();
      a     = pickOperand();
      b     = pickOperand();
      if ($urandom_range(0, 499) == 0) begin
        #2 clr = 1'b0;
      end
    end
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
